tx_axis_frame_arbiter: RTL and testbench
========================================

// Module: tx_axis_frame_arbiter
// PURPOSE
//  - Frame-level AXIS arbiter that shares the single tx_mac AXIS slave input between NUM_PORTS AXIS sources.
//  - A grant is held for a whole frame, from the first beat to tlast, so frames never interleave.
//  - Inserts a configurable idle gap between frames so the MAC can re-arm its tready.
//  - Truncates over-length frames: forces tlast downstream, then drains the rest of the source frame.
// PARAMETERS
//  NUM_PORTS        2   number of AXIS requesters (2..8)
//  AXIS_DATA_WIDTH  32  tdata width, bits
//  AXIS_DATA_BYTES  AXIS_DATA_WIDTH/8  tkeep width
//  MAX_BEATS        380 max beats per frame forwarded (1518B / 4B, rounded up)
//  GAP_CYCLES       2   idle cycles after each frame (>=1)
// PORTS
//  tx_clk          in   1                  clock
//  tx_rst          in   1                  synchronous reset, active-high
//  s_tdata         in   NUM_PORTS*AXIS_DATA_WIDTH  source data; port k at [k*W +: W]
//  s_tkeep         in   NUM_PORTS*AXIS_DATA_BYTES  source byte enables
//  s_tvalid        in   NUM_PORTS          per-source valid
//  s_tlast         in   NUM_PORTS          per-source last
//  s_tready        out  NUM_PORTS          per-source ready
//  m_tdata         out  AXIS_DATA_WIDTH    to tx_mac in_slave_tx_tdata
//  m_tkeep         out  AXIS_DATA_BYTES    to tx_mac in_slave_tx_tkeep
//  m_tvalid        out  1                  to tx_mac in_slave_tx_tvalid
//  m_tlast         out  1                  to tx_mac in_slave_tx_tlast
//  m_tready        in   1                  from tx_mac out_slave_tx_tready
//  grant           out  NUM_PORTS          one-hot active grant; 0 when idle
//  busy            out  1                  high in PASS or DROP
//  frame_done      out  1                  1-cycle pulse on each accepted downstream tlast
//  oversize_error  out  1                  1-cycle pulse on entering DROP
//  frame_count     out  16                 count of frames ending with a genuine source tlast
// BEHAVIOUR
//  - Reset (tx_rst=1 at a clock edge):
//    - state=IDLE; grant=0; busy=0; frame_done=0; oversize_error=0; frame_count=0.
//    - beat_cnt=0; rr_ptr=NUM_PORTS-1, so port 0 wins first.
//    - Reset mid-frame abandons the frame immediately; no tlast is generated.
//  - States:
//    - IDLE: all s_tready=0; m_tvalid=0.
//      - If any s_tvalid: grant <= first requester searching rr_ptr+1 .. rr_ptr (mod N).
//      - Then rr_ptr <= winner; -> PASS. Grant is registered, so 1 cycle arbitration latency.
//    - PASS: zero-latency combinational path for granted port g.
//      - m_tdata/m_tkeep/m_tvalid = source g; s_tready[g] = m_tready; other s_tready = 0.
//      - m_tlast = s_tlast[g] | (beat_cnt == MAX_BEATS-1).
//      - On each accepted beat (m_tvalid & m_tready): beat_cnt++.
//      - Accepted beat with s_tlast[g]: frame_done pulse; frame_count++ (wraps 0xFFFF->0); -> GAP.
//      - Accepted beat with beat_cnt==MAX_BEATS-1 and !s_tlast[g]: frame_done pulse; oversize_error pulse; -> DROP.
//      - s_tvalid[g] low mid-frame: hold in PASS indefinitely; no timeout.
//    - DROP: m_tvalid=0; s_tready[g]=1; beats are discarded.
//      - On s_tvalid[g]&s_tlast[g]: -> GAP. frame_count does not increment.
//    - GAP: grant=0; all s_tready=0; count GAP_CYCLES cycles; -> IDLE.
//  - beat_cnt width $clog2(MAX_BEATS+1); cleared on entry to GAP.
//  - A single-beat frame (tlast on first beat) is legal: PASS lasts 1 accepted cycle.
//  - Simultaneous requests: round-robin order only.
//  - Requests rising during GAP wait until IDLE.
//  - m_* outputs are 0 whenever m_tvalid=0; downstream must treat them as don't-care.
// CONFIGURATION
//  - TX_ARB_STRICT_PRIO_EN defined:
//    - IDLE picks the lowest-index requesting port; rr_ptr is unused.
//    - Port 0 can starve the others.
//  - Undefined (default): round-robin as above.
//  - All other behaviour is identical in both builds.
// TESTING
//  - Reset: hold tx_rst 3 cycles -> grant=0, s_tready=0, frame_count=0, m_tvalid=0.
//  - Single port: port0 sends 16 beats, tkeep 4'hF, last tkeep 4'hC.
//    - m_* matches beat-for-beat, grant=01; frame_done after beat 16; frame_count=1.
//  - Contention: both ports valid at the same cycle, 4 frames each.
//    - Grants alternate 0,1,0,1...; no interleaving; >=GAP_CYCLES idle between frames.
//    - With TX_ARB_STRICT_PRIO_EN: all port0 frames go first.
//  - Backpressure: m_tready toggles randomly on a 20-beat frame.
//    - s_tready[g] mirrors m_tready; no beat is lost or duplicated.
//  - Oversize: port1 sends 400 beats.
//    - Downstream sees 380 beats with m_tlast on beat 380; oversize_error pulses once.
//    - 20 beats are drained; frame_count unchanged.
//  - Reset mid-frame at beat 5: next cycle grant=0, state IDLE; a new frame from port0 passes intact.

Source files
------------

// File: rtl/tx_axis_frame_arbiter.sv
// ============================================================================
// Module   : tx_axis_frame_arbiter
// Purpose  : Frame-level AXIS arbiter feeding one tx_mac slave from NUM_PORTS
//            sources, with an inter-frame gap and over-length truncation.
// Option   : TX_ARB_STRICT_PRIO_EN selects lowest-index-wins arbitration.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tx_axis_frame_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int AXIS_DATA_BYTES = AXIS_DATA_WIDTH / 8,
  parameter int MAX_BEATS       = 380,
  parameter int GAP_CYCLES      = 2
) (
  input  logic                                 tx_clk,
  input  logic                                 tx_rst,
  input  logic [NUM_PORTS*AXIS_DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS*AXIS_DATA_BYTES-1:0] s_tkeep,
  input  logic [NUM_PORTS-1:0]                 s_tvalid,
  input  logic [NUM_PORTS-1:0]                 s_tlast,
  output logic [NUM_PORTS-1:0]                 s_tready,
  output logic [AXIS_DATA_WIDTH-1:0]           m_tdata,
  output logic [AXIS_DATA_BYTES-1:0]           m_tkeep,
  output logic                                 m_tvalid,
  output logic                                 m_tlast,
  input  logic                                 m_tready,
  output logic [NUM_PORTS-1:0]                 grant,
  output logic                                 busy,
  output logic                                 frame_done,
  output logic                                 oversize_error,
  output logic [15:0]                          frame_count
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int BW = $clog2(MAX_BEATS + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         gidx_q, gidx_d;
  logic [NUM_PORTS-1:0]  grant_q, grant_d;
  logic [BW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  frame_done_q, frame_done_d;
  logic                  oversize_q, oversize_d;

  logic                  req_any;
  logic [PW-1:0]         win_idx;
  logic                  g_valid;
  logic                  g_last;
  logic                  at_max;

  assign req_any = |s_tvalid;
  assign g_valid = s_tvalid[gidx_q];
  assign g_last  = s_tlast[gidx_q];
  assign at_max  = (beat_cnt_q == BW'(MAX_BEATS - 1));

`ifdef TX_ARB_STRICT_PRIO_EN
  always_comb begin
    win_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (s_tvalid[i]) win_idx = PW'(i);
    end
  end
`else
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW:0]   rr_sum;

  // Scan from the highest offset down so the nearest requester after rr_ptr wins.
  always_comb begin
    win_idx = '0;
    rr_sum  = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      rr_sum = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (rr_sum >= (PW+1)'(NUM_PORTS)) rr_sum = rr_sum - (PW+1)'(NUM_PORTS);
      if (s_tvalid[rr_sum[PW-1:0]]) win_idx = rr_sum[PW-1:0];
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (state_q == ST_IDLE && req_any) rr_ptr_d = win_idx;
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) rr_ptr_q <= PW'(NUM_PORTS - 1);
    else        rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    state_d       = state_q;
    gidx_d        = gidx_q;
    grant_d       = grant_q;
    beat_cnt_d    = beat_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    frame_count_d = frame_count_q;
    frame_done_d  = 1'b0;
    oversize_d    = 1'b0;
    s_tready      = '0;
    m_tdata       = '0;
    m_tkeep       = '0;
    m_tvalid      = 1'b0;
    m_tlast       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          gidx_d  = win_idx;
          grant_d = {{(NUM_PORTS-1){1'b0}}, 1'b1} << win_idx;
          state_d = ST_PASS;
        end
      end

      ST_PASS: begin
        s_tready[gidx_q] = m_tready;
        m_tvalid         = g_valid;
        if (g_valid) begin
          m_tdata = s_tdata[int'(gidx_q)*AXIS_DATA_WIDTH +: AXIS_DATA_WIDTH];
          m_tkeep = s_tkeep[int'(gidx_q)*AXIS_DATA_BYTES +: AXIS_DATA_BYTES];
          m_tlast = g_last | at_max;
        end
        if (g_valid && m_tready) begin
          beat_cnt_d = beat_cnt_q + BW'(1);
          if (g_last) begin
            frame_done_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            grant_d       = '0;
            beat_cnt_d    = '0;
            state_d       = ST_GAP;
          end else if (at_max) begin
            frame_done_d = 1'b1;
            oversize_d   = 1'b1;
            state_d      = ST_DROP;
          end
        end
      end

      // Grant stays asserted while the tail of the truncated frame is swallowed.
      ST_DROP: begin
        s_tready[gidx_q] = 1'b1;
        if (g_valid && g_last) begin
          grant_d    = '0;
          beat_cnt_d = '0;
          state_d    = ST_GAP;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
          gap_cnt_d = '0;
          state_d   = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      state_q       <= ST_IDLE;
      gidx_q        <= '0;
      grant_q       <= '0;
      beat_cnt_q    <= '0;
      gap_cnt_q     <= '0;
      frame_count_q <= '0;
      frame_done_q  <= 1'b0;
      oversize_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      gidx_q        <= gidx_d;
      grant_q       <= grant_d;
      beat_cnt_q    <= beat_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      frame_count_q <= frame_count_d;
      frame_done_q  <= frame_done_d;
      oversize_q    <= oversize_d;
    end
  end

  assign grant          = grant_q;
  assign busy           = (state_q == ST_PASS) || (state_q == ST_DROP);
  assign frame_done     = frame_done_q;
  assign oversize_error = oversize_q;
  assign frame_count    = frame_count_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_axis_frame_arbiter.sv
// ============================================================================
// Module   : tb_tx_axis_frame_arbiter
// Purpose  : Scoreboard bench for tx_axis_frame_arbiter with a frame table
//            plus contention, oversize and mid-frame reset sequences.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_tx_axis_frame_arbiter;

  localparam int N    = 2;
  localparam int W    = 32;
  localparam int B    = 4;
  localparam int MAXB = 380;
  localparam int GAP  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] s_tdata;
  logic [N*B-1:0] s_tkeep;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tlast;
  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic [B-1:0]   m_tkeep;
  logic           m_tvalid;
  logic           m_tlast;
  logic           m_tready;
  logic [N-1:0]   grant;
  logic           busy;
  logic           frame_done;
  logic           oversize_error;
  logic [15:0]    frame_count;

  tx_axis_frame_arbiter #(
    .NUM_PORTS(N), .AXIS_DATA_WIDTH(W), .AXIS_DATA_BYTES(B),
    .MAX_BEATS(MAXB), .GAP_CYCLES(GAP)
  ) dut (
    .tx_clk(clk), .tx_rst(rst),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .busy(busy), .frame_done(frame_done),
    .oversize_error(oversize_error), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_t;

  typedef struct {
    int         port;
    int         len;
    logic [3:0] lkeep;
    bit         bp;
    logic [1:0] exp_grant;
    int         exp_fc;
  } vec_t;

  beat_t src0[$];
  beat_t src1[$];
  exp_t  exp_q[$];

  int checks   = 0;
  int errors   = 0;
  int fd_cnt   = 0;
  int ov_cnt   = 0;
  int acc_cnt  = 0;
  int fire1_tot = 0;
  int fid      = 0;
  int exp_fc   = 0;
  bit bp_en    = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  // Source beats carry {port, frame id, beat index} so any reorder or loss shows up.
  task automatic queue_frame(input int port, input int len, input logic [3:0] lkeep);
    beat_t b;
    exp_t  e;
    int    exp_len;
    exp_len = (len > MAXB) ? MAXB : len;
    for (int i = 0; i < len; i++) begin
      b.data = {4'(port), 12'(fid), 16'(i)};
      b.keep = (i == len - 1) ? lkeep : 4'hF;
      b.last = (i == len - 1);
      if (port == 0) src0.push_back(b);
      else           src1.push_back(b);
      if (i < exp_len) begin
        e.port = 2'(port);
        e.data = b.data;
        e.keep = b.keep;
        e.last = (i == len - 1) || (i == exp_len - 1);
        exp_q.push_back(e);
      end
    end
    fid++;
  endtask

  task automatic wait_idle(input int limit, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (src0.size() == 0 && src1.size() == 0 && exp_q.size() == 0 && !busy)
        done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout after %0d cycles, %0d beats outstanding", name, limit, exp_q.size());
    end
    repeat (GAP + 2) @(negedge clk);
  endtask

  task automatic wait_busy(input int limit, input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < limit && !done; c++) begin
      @(negedge clk);
      if (busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: busy never rose within %0d cycles", name, limit);
    end
  endtask

  // Source driver: handshakes are decided at negedge, queues advance just after posedge.
  initial begin
    bit fire0, fire1;
    forever begin
      @(negedge clk);
      fire0 = s_tvalid[0] & s_tready[0];
      fire1 = s_tvalid[1] & s_tready[1];
      @(posedge clk);
      #1;
      if (fire0 && src0.size() > 0) void'(src0.pop_front());
      if (fire1 && src1.size() > 0) begin
        void'(src1.pop_front());
        fire1_tot++;
      end
      if (src0.size() > 0) begin
        s_tvalid[0] = 1'b1; s_tdata[31:0] = src0[0].data;
        s_tkeep[3:0] = src0[0].keep; s_tlast[0] = src0[0].last;
      end else begin
        s_tvalid[0] = 1'b0; s_tdata[31:0] = '0; s_tkeep[3:0] = '0; s_tlast[0] = 1'b0;
      end
      if (src1.size() > 0) begin
        s_tvalid[1] = 1'b1; s_tdata[63:32] = src1[0].data;
        s_tkeep[7:4] = src1[0].keep; s_tlast[1] = src1[0].last;
      end else begin
        s_tvalid[1] = 1'b0; s_tdata[63:32] = '0; s_tkeep[7:4] = '0; s_tlast[1] = 1'b0;
      end
      m_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Downstream monitor and scoreboard.
  initial begin
    exp_t e;
    bit   after_last;
    int   idle;
    after_last = 1'b0;
    idle       = 0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (frame_done)     fd_cnt++;
        if (oversize_error) ov_cnt++;
        if (busy && m_tvalid)
          chk("tready_mirror", 64'(s_tready), 64'(grant & {N{m_tready}}));
        if (!m_tvalid)
          chk("idle_outputs_zero", {27'd0, m_tlast, m_tkeep, m_tdata}, 64'd0);
        if (after_last) begin
          if (!m_tvalid) idle++;
          else begin
            chk("frame_gap_ok", 64'(idle >= GAP), 64'd1);
            after_last = 1'b0;
          end
        end
        if (m_tvalid && m_tready) begin
          acc_cnt++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %0h required no beat", m_tdata);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data",  64'(m_tdata), 64'(e.data));
            chk("beat_keep",  64'(m_tkeep), 64'(e.keep));
            chk("beat_last",  64'(m_tlast), 64'(e.last));
            chk("beat_grant", 64'(grant),   64'(2'b01 << e.port));
          end
          if (m_tlast) begin
            after_last = 1'b1;
            idle       = 0;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    int   fd0, ov0, acc0, f1_0;
    bit   hit;

    vt[0] = '{port: 0, len: 16, lkeep: 4'hC, bp: 1'b0, exp_grant: 2'b01, exp_fc: 1};
    vt[1] = '{port: 1, len: 1,  lkeep: 4'h1, bp: 1'b0, exp_grant: 2'b10, exp_fc: 2};
    vt[2] = '{port: 0, len: 20, lkeep: 4'h7, bp: 1'b1, exp_grant: 2'b01, exp_fc: 3};
    vt[3] = '{port: 1, len: 20, lkeep: 4'hF, bp: 1'b1, exp_grant: 2'b10, exp_fc: 4};
    vt[4] = '{port: 1, len: 3,  lkeep: 4'h3, bp: 1'b0, exp_grant: 2'b10, exp_fc: 5};

    rst = 1'b1; s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tlast = '0; m_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_grant",       64'(grant),          64'd0);
    chk("rst_s_tready",    64'(s_tready),       64'd0);
    chk("rst_frame_count", 64'(frame_count),    64'd0);
    chk("rst_m_tvalid",    64'(m_tvalid),       64'd0);
    chk("rst_busy",        64'(busy),           64'd0);
    chk("rst_pulses",      64'({frame_done, oversize_error}), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      bp_en = vt[i].bp;
      fd0 = fd_cnt; ov0 = ov_cnt;
      queue_frame(vt[i].port, vt[i].len, vt[i].lkeep);
      wait_busy(20, "vec_busy");
      chk("vec_grant", 64'(grant), 64'(vt[i].exp_grant));
      wait_idle(2000, "vec_drain");
      exp_fc++;
      chk("vec_frame_count", 64'(frame_count), 64'(vt[i].exp_fc));
      chk("vec_frame_done",  64'(fd_cnt - fd0), 64'd1);
      chk("vec_no_oversize", 64'(ov_cnt - ov0), 64'd0);
    end
    bp_en = 1'b0;

    // Contention: last winner was port 1, so round-robin restarts at port 0.
    fd0 = fd_cnt;
`ifdef TX_ARB_STRICT_PRIO_EN
    for (int f = 0; f < 4; f++) queue_frame(0, 5 + f, 4'hF);
    for (int f = 0; f < 4; f++) queue_frame(1, 5 + f, 4'hF);
`else
    for (int f = 0; f < 4; f++) begin
      queue_frame(0, 5 + f, 4'hF);
      queue_frame(1, 5 + f, 4'hF);
    end
`endif
    wait_idle(3000, "contention_drain");
    exp_fc += 8;
    chk("cont_frame_count", 64'(frame_count), 64'(exp_fc));
    chk("cont_frame_done",  64'(fd_cnt - fd0), 64'd8);

    // Oversize: 400-beat frame truncated to MAXB beats, tail drained.
    fd0 = fd_cnt; ov0 = ov_cnt; f1_0 = fire1_tot;
    queue_frame(1, 400, 4'hF);
    wait_idle(5000, "oversize_drain");
    chk("ovs_error_pulses", 64'(ov_cnt - ov0),       64'd1);
    chk("ovs_frame_done",   64'(fd_cnt - fd0),       64'd1);
    chk("ovs_frame_count",  64'(frame_count),        64'(exp_fc));
    chk("ovs_src_consumed", 64'(fire1_tot - f1_0),   64'd400);

    // Reset after the fifth accepted beat of a port 0 frame.
    acc0 = acc_cnt;
    queue_frame(0, 10, 4'hF);
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk); #3;
      if (acc_cnt - acc0 >= 5) hit = 1'b1;
    end
    chk("mid_reset_reached_beat5", 64'(hit), 64'd1);
    rst = 1'b1;
    s_tvalid = '0;
    src0.delete();
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    chk("mid_reset_grant",    64'(grant),       64'd0);
    chk("mid_reset_busy",     64'(busy),        64'd0);
    chk("mid_reset_m_tvalid", 64'(m_tvalid),    64'd0);
    chk("mid_reset_count",    64'(frame_count), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    exp_fc = 0;
    fd0 = fd_cnt;
    queue_frame(0, 8, 4'h3);
    wait_busy(20, "post_reset_busy");
    chk("post_reset_grant", 64'(grant), 64'b01);
    wait_idle(2000, "post_reset_drain");
    exp_fc++;
    chk("post_reset_frame_count", 64'(frame_count), 64'(exp_fc));
    chk("post_reset_frame_done",  64'(fd_cnt - fd0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
